aclk_key_ctrl: RTL and testbench

- Alarm-clock keypad controller that sequences the 4-digit key shift register and the alarm/time load paths.
- Decodes keypad codes and issues shift/clear strobes to the key buffer.
- Commits a fully entered 4-digit value as new alarm or new time.
- Abandons entry after an inactivity timeout. Sits between the keypad decoder and the key register, alarm register and time counter.

---
 rtl/aclk_pkg.sv | 24 ++
 rtl/aclk_timeout_cnt.sv | 31 +++
 rtl/aclk_key_ctrl.sv | 104 ++++++++++
 tb/tb_aclk_key_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared types and key codes for the alarm-clock keypad controller.
package aclk_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_CLEAR,
        KEY_STORED,
        KEY_WAIT,
        KEY_ENTRY,
        LOAD_A,
        LOAD_C,
        SHOW_ALARM
    } state_t;

    localparam logic [3:0] KEY_ALARM = 4'd10;
    localparam logic [3:0] KEY_TIME  = 4'd11;
    localparam logic [3:0] KEY_NOKEY = 4'd15;

    // Codes 0..9 are digit keys.
    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/aclk_timeout_cnt.sv
// Inactivity timer: counts one_second pulses while enabled and not cleared.
module aclk_timeout_cnt #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic one_second,
    output logic timeout
);

    localparam logic [3:0] LAST = 4'(TIMEOUT_S - 1);

    logic [3:0] cnt;

    // Key activity (clr) overrides a coincident second pulse.
    assign timeout = en && !clr && one_second && (cnt == LAST);

    // Second counter, held at zero outside the entry states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (one_second) begin
            cnt <= timeout ? '0 : cnt + 4'd1;
        end
    end

endmodule

// File: rtl/aclk_key_ctrl.sv
// Alarm-clock keypad controller: sequences key-register shift/clear and
// the alarm/time load strobes. All outputs decode from the registered state.
module aclk_key_ctrl
    import aclk_pkg::*;
#(
    parameter int unsigned TIMEOUT_S  = 10,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       one_second,
    output logic       shift,
    output logic       kr_clear,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       show_new_time,
    output logic       show_a
);

    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] DIG_FULL = CW'(NUM_DIGITS);

    state_t        state_q, state_d;
    logic [CW-1:0] digit_cnt;
    logic          key_digit, key_alarm, key_time, key_active, key_none;
    logic          entry_st, timeout;

    assign key_digit  = is_digit(key);
    assign key_alarm  = (key == KEY_ALARM);
    assign key_time   = (key == KEY_TIME);
    assign key_active = key_digit || key_alarm || key_time;
    // Codes 12..14 behave exactly like NOKEY.
    assign key_none   = !key_active;
    assign entry_st   = (state_q == KEY_WAIT) || (state_q == KEY_ENTRY);

    aclk_timeout_cnt #(
        .TIMEOUT_S (TIMEOUT_S)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .en         (entry_st),
        .clr        (key_active),
        .one_second (one_second),
        .timeout    (timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= SHOW_TIME;
        else        state_q <= state_d;
    end

    // Digit counter: saturates at NUM_DIGITS, cleared whenever SHOW_TIME is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_cnt <= '0;
        end else if (state_d == SHOW_TIME) begin
            digit_cnt <= '0;
        end else if (state_q == KEY_STORED && digit_cnt != DIG_FULL) begin
            digit_cnt <= digit_cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SHOW_TIME: begin
                if (key_alarm)      state_d = SHOW_ALARM;
                else if (key_digit) state_d = KEY_CLEAR;
            end
            KEY_CLEAR:  state_d = KEY_STORED;
            KEY_STORED: state_d = KEY_WAIT;
            KEY_WAIT: begin
                if (key_none)     state_d = KEY_ENTRY;
                else if (timeout) state_d = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (key_digit)      state_d = KEY_STORED;
                else if (key_alarm) state_d = (digit_cnt == DIG_FULL) ? LOAD_A : SHOW_TIME;
                else if (key_time)  state_d = (digit_cnt == DIG_FULL) ? LOAD_C : SHOW_TIME;
                else if (timeout)   state_d = SHOW_TIME;
            end
            LOAD_A, LOAD_C: state_d = SHOW_TIME;
            SHOW_ALARM: begin
                if (!key_alarm) state_d = SHOW_TIME;
            end
            default: state_d = SHOW_TIME;
        endcase
    end

    // Moore output decode.
    always_comb begin
        kr_clear      = (state_q == KEY_CLEAR);
        shift         = (state_q == KEY_STORED);
        load_new_a    = (state_q == LOAD_A);
        load_new_c    = (state_q == LOAD_C);
        show_a        = (state_q == SHOW_ALARM);
        show_new_time = (state_q == KEY_CLEAR) || (state_q == KEY_STORED) ||
                        (state_q == KEY_WAIT)  || (state_q == KEY_ENTRY);
    end

endmodule

// File: tb/tb_aclk_key_ctrl.sv
// Testbench for aclk_key_ctrl: directed scenarios plus randomized key entries
// checked against a transaction-level expectation of strobe counts.
module tb_aclk_key_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic       one_second;
    logic       shift, kr_clear, load_new_a, load_new_c, show_new_time, show_a;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // Strobe-cycle totals seen by the monitor.
    int unsigned tot_clr = 0, tot_shift = 0, tot_la = 0, tot_lc = 0, tot_sa = 0;
    int unsigned s_clr, s_shift, s_la, s_lc, s_sa;

    aclk_key_ctrl #(
        .TIMEOUT_S  (10),
        .NUM_DIGITS (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key           (key),
        .one_second    (one_second),
        .shift         (shift),
        .kr_clear      (kr_clear),
        .load_new_a    (load_new_a),
        .load_new_c    (load_new_c),
        .show_new_time (show_new_time),
        .show_a        (show_a)
    );

    always #5 clk = ~clk;

    // Count high cycles of each strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (kr_clear)   tot_clr++;
        if (shift)      tot_shift++;
        if (load_new_a) tot_la++;
        if (load_new_c) tot_lc++;
        if (show_a)     tot_sa++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_clr = tot_clr; s_shift = tot_shift; s_la = tot_la; s_lc = tot_lc; s_sa = tot_sa;
    endtask

    task automatic press(input logic [3:0] d, input int unsigned hold, input int unsigned gap);
        key = d;
        repeat (hold) tick();
        key = 4'd15;
        repeat (gap) tick();
    endtask

    // Expected strobe counts for a whole entry of n digits closed by term.
    function automatic int unsigned exp_load(input int unsigned n, input logic [3:0] term,
                                             input logic [3:0] which);
        return (n >= 4 && term == which) ? 1 : 0;
    endfunction

    initial begin
        int unsigned n, hold, gap;
        logic [3:0]  term;

        reset = 1'b0; key = 4'd15; one_second = 1'b0;
        #1;
        check("reset_shift", shift, 0);
        check("reset_snt", show_new_time, 0);
        check("reset_sa", show_a, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Reset mid-entry: three digits stored, fourth in progress.
        snap();
        press(4'd1, 3, 2); press(4'd2, 3, 2); press(4'd3, 3, 2);
        key = 4'd4; tick();
        check("mid_shift_hi", shift, 1);
        reset = 1'b0; #1;
        check("async_shift", shift, 0);
        check("async_snt", show_new_time, 0);
        key = 4'd15; tick(); reset = 1'b1; tick();
        key = 4'd10; tick();
        check("post_reset_alarm", show_a, 1);
        key = 4'd15; tick(); tick();
        check("post_reset_loads", (tot_la - s_la) + (tot_lc - s_lc), 0);

        // Four digits then TIME: one clear, four shifts, one time load.
        snap();
        key = 4'd1; tick();
        check("clr_first", kr_clear, 1);
        check("clr_no_shift", tot_shift - s_shift, 0);
        repeat (2) tick(); key = 4'd15; repeat (2) tick();
        press(4'd2, 3, 2); press(4'd3, 3, 2); press(4'd4, 3, 2);
        key = 4'd11; tick();
        check("loadc_hi", load_new_c, 1);
        key = 4'd15; tick();
        check("loadc_one", load_new_c, 0);
        check("snt_after", show_new_time, 0);
        tick();
        check("t2_clr", tot_clr - s_clr, 1);
        check("t2_shift", tot_shift - s_shift, 4);
        check("t2_lc", tot_lc - s_lc, 1);

        // Short entry cancelled by ALARM.
        snap();
        press(4'd1, 3, 2); press(4'd2, 3, 2);
        key = 4'd10; tick(); key = 4'd15; tick(); tick();
        check("cancel_la", tot_la - s_la, 0);
        check("cancel_snt", show_new_time, 0);
        // Counter must have restarted: three more digits are still too few.
        snap();
        press(4'd7, 3, 2); press(4'd8, 3, 2); press(4'd9, 3, 2);
        key = 4'd11; tick(); key = 4'd15; tick(); tick();
        check("cnt_cleared_lc", tot_lc - s_lc, 0);

        // Timeout on the 10th one_second pulse.
        snap();
        press(4'd5, 3, 2);
        for (int i = 1; i <= 10; i++) begin
            one_second = 1'b1; tick(); one_second = 1'b0; tick();
            if (i == 9) check("to_before", show_new_time, 1);
        end
        check("to_after", show_new_time, 0);
        check("to_loads", (tot_la - s_la) + (tot_lc - s_lc), 0);

        // Digit coincident with the 10th pulse wins.
        press(4'd5, 3, 2);
        for (int i = 1; i <= 9; i++) begin
            one_second = 1'b1; tick(); one_second = 1'b0; tick();
        end
        one_second = 1'b1; key = 4'd6; tick(); one_second = 1'b0;
        check("to_key_wins", shift, 1);
        key = 4'd15; repeat (2) tick();
        key = 4'd11; tick(); key = 4'd15; repeat (2) tick();

        // Six digits then ALARM.
        snap();
        for (int d = 0; d < 6; d++) press(4'(d), 3, 2);
        key = 4'd10; tick();
        check("loada_hi", load_new_a, 1);
        key = 4'd15; tick(); tick();
        check("six_shift", tot_shift - s_shift, 6);
        check("six_la", tot_la - s_la, 1);

        // ALARM held for 20 cycles.
        snap();
        key = 4'd10;
        repeat (20) tick();
        check("sa_held", show_a, 1);
        key = 4'd15; tick();
        check("sa_drop", show_a, 0);
        check("sa_cycles", tot_sa - s_sa, 20);

        // Codes 12..14 inside an entry are ignored.
        press(4'd3, 3, 2);
        for (int c = 12; c <= 14; c++) begin
            key = 4'(c); tick();
            check("ignored_snt", show_new_time, 1);
            check("ignored_shift", shift, 0);
        end
        key = 4'd11; tick(); key = 4'd15; repeat (2) tick();

        // Randomized entries.
        for (int t = 0; t < 16; t++) begin
            n    = $urandom_range(1, 7);
            term = ($urandom_range(0, 1) == 0) ? 4'd10 : 4'd11;
            snap();
            for (int i = 0; i < int'(n); i++) begin
                hold = $urandom_range(3, 5);
                gap  = $urandom_range(2, 3);
                press(4'($urandom_range(0, 9)), hold, gap);
            end
            check("rnd_in_entry", show_new_time, 1);
            key = term; tick(); key = 4'd15; repeat (3) tick();
            check("rnd_clr", tot_clr - s_clr, 1);
            check("rnd_shift", tot_shift - s_shift, n);
            check("rnd_la", tot_la - s_la, exp_load(n, term, 4'd10));
            check("rnd_lc", tot_lc - s_lc, exp_load(n, term, 4'd11));
            check("rnd_idle", {show_new_time, show_a}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
